regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters.
- Requester 0 is the core writeback path. Its destination is selected internally from rt, rd or $31.
- Requester 1 is a long-latency auxiliary unit, such as a multiply/divide result, held in a one-entry buffer.
- Core writes have priority. A wait counter bounds auxiliary starvation by stalling the core for one cycle.

Parameters:
- MAX_WAIT, 4, number of HOLD cycles an auxiliary entry may lose arbitration before the core is forced to stall (legal range 1..15).
- DATA_W, 32, write-data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- core_we  in  1  core writeback enable.
- core_rt  in  5  instruction bits [20:16].
- core_rd  in  5  instruction bits [15:11].
- core_reg_dst  in  2  destination select: 00 = rt, 01 = rd, 10 = $31, 11 = rt.
- core_wdata  in  DATA_W  core writeback data.
- core_stall  out  1  core must hold its current writeback for one cycle.
- aux_valid  in  1  auxiliary result offered.
- aux_dest  in  5  auxiliary destination register.
- aux_data  in  DATA_W  auxiliary result data.
- aux_ready  out  1  buffer can accept; transfer occurs when aux_valid & aux_ready.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst). All state changes occur on the rising edge of clk.
- Reset values:
  - state = IDLE, wait_cnt = 0, buffer valid = 0.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, core_stall = 0.
  - aux_ready = 0 while rst = 1.
- Core destination: dest = mux(core_reg_dst). The core request is effective when core_we = 1 and dest != 0. Writes to $0 never reach the port.
- Output latency: the grant decided in cycle N appears on rf_* in cycle N+1. When neither requester is granted, rf_we = 0 and rf_waddr/rf_wdata hold their last values.
- aux_ready = (state == IDLE) & ~rst. It is combinational from the state register.
- FSM states:
  - IDLE: buffer empty.
    - Core effective -> grant core.
    - aux handshake with aux_dest != 0 -> capture into buffer, next state HOLD, wait_cnt = 0.
    - aux handshake with aux_dest == 0 -> accept and discard, stay IDLE.
    - A captured entry is never granted in its capture cycle.
  - HOLD: buffer full.
    - Core not effective -> grant aux, next state IDLE.
    - Core effective, buffered dest == core dest -> grant core, drop the aux entry (the core result is younger), next state IDLE, wait_cnt = 0.
    - Core effective, dests differ -> grant core, wait_cnt + 1. When wait_cnt reaches MAX_WAIT-1, next state FORCE.
  - FORCE: core_stall = 1 (Moore output).
    - Grant aux. Ignore core inputs, because the core re-presents the same writeback next cycle.
    - Next state IDLE, wait_cnt = 0.
- core_stall is 1 only in FORCE, and never for more than one consecutive cycle.
- wait_cnt is 4 bits wide and saturates; it never wraps.
- Reset mid-operation: any buffered entry is discarded. No rf_we pulse is issued in the cycle after the rst edge.

Decomposition:
- Shared package (wb_pkg):
  - REG_DST_RT = 2'b00, REG_DST_RD = 2'b01, REG_DST_RA = 2'b10.
  - RA_REG = 5'd31, ZERO_REG = 5'd0.
  - State enum {IDLE, HOLD, FORCE}.
- One sub-module: wb_dest_sel, a combinational destination mux (rt/rd/rt-default/$31, zero-detect output) instantiated for the core path.

Test Plan:
1. Core only: core_we=1, reg_dst=01, rd=5, rt=9, wdata=0xDEADBEEF in cycle 0 -> cycle 1: rf_we=1, waddr=5, wdata=0xDEADBEEF. Repeat with reg_dst=10 -> waddr=31. Repeat with reg_dst=11 -> waddr=9.
2. $0 suppression: core_we=1, reg_dst=00, rt=0 -> rf_we stays 0. Aux offer with aux_dest=0 -> aux_ready stays 1, no write.
3. Aux, idle core: aux_valid=1, dest=7, data=0x1234 in cycle 0 -> aux_ready=0 in cycle 1 with grant; cycle 2: rf_we=1, waddr=7, wdata=0x1234; aux_ready=1 again.
4. Starvation (MAX_WAIT=4): aux dest=7 captured, then core writes dest=3 every cycle -> 4 HOLD cycles of core writes, then core_stall=1 for exactly one cycle. The next rf cycle writes reg 7 = aux data; the following cycle resumes the core write to reg 3.
5. Same-dest drop: aux dest=12 buffered, then core writes dest=12 data=0xAA -> only 0xAA written to reg 12; aux_ready=1 the next cycle; no later write of aux data.
6. Reset in HOLD: assert rst for one cycle while the buffer is full -> rf_we=0, core_stall=0. After release, aux_ready=1 and no write of the stale entry ever occurs.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package wb_pkg;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [4:0] RA_REG   = 5'd31;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FORCE
  } wb_state_t;

endpackage

// File: rtl/wb_dest_sel.sv
// Core writeback destination mux: rt, rd or $31 (encoding 11 falls back to rt).
module wb_dest_sel
  import wb_pkg::*;
(
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [1:0] reg_dst,
  output logic [4:0] dest,
  output logic       is_zero
);

  always_comb begin
    dest = rt;
    case (reg_dst)
      REG_DST_RD: dest = rd;
      REG_DST_RA: dest = RA_REG;
      default:    dest = rt;
    endcase
    is_zero = (dest == ZERO_REG);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the core writeback path
// and a one-entry auxiliary result buffer, with bounded auxiliary starvation.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_we,
  input  logic [4:0]        core_rt,
  input  logic [4:0]        core_rd,
  input  logic [1:0]        core_reg_dst,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  input  logic              aux_valid,
  input  logic [4:0]        aux_dest,
  input  logic [DATA_W-1:0] aux_data,
  output logic              aux_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  wb_state_t         state;
  logic [3:0]        wait_cnt;
  logic [4:0]        buf_dest;
  logic [DATA_W-1:0] buf_data;

  logic [4:0] core_dest;
  logic       core_dest_zero;
  logic       core_eff;

  wb_dest_sel u_dest_sel (
    .rt      (core_rt),
    .rd      (core_rd),
    .reg_dst (core_reg_dst),
    .dest    (core_dest),
    .is_zero (core_dest_zero)
  );

  assign core_eff  = core_we & ~core_dest_zero;
  assign aux_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      buf_dest   <= '0;
      buf_data   <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      core_stall <= 1'b0;
    end else begin
      rf_we      <= 1'b0;
      core_stall <= 1'b0;
      case (state)
        IDLE: begin
          if (core_eff) begin
            rf_we    <= 1'b1;
            rf_waddr <= core_dest;
            rf_wdata <= core_wdata;
          end
          // aux_ready is high here, so aux_valid alone is a handshake
          if (aux_valid && aux_dest != ZERO_REG) begin
            buf_dest <= aux_dest;
            buf_data <= aux_data;
            wait_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!core_eff) begin
            rf_we    <= 1'b1;
            rf_waddr <= buf_dest;
            rf_wdata <= buf_data;
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            rf_we    <= 1'b1;
            rf_waddr <= core_dest;
            rf_wdata <= core_wdata;
            if (core_dest == buf_dest) begin
              wait_cnt <= '0;
              state    <= IDLE;
            end else begin
              if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
              if (wait_cnt == WAIT_LAST) begin
                state      <= FORCE;
                core_stall <= 1'b1;
              end
            end
          end
        end
        FORCE: begin
          rf_we    <= 1'b1;
          rf_waddr <= buf_dest;
          rf_wdata <= buf_data;
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a transaction-level model.
module tb_regfile_wb_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned DATA_W   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_we;
  logic [4:0]        core_rt, core_rd;
  logic [1:0]        core_reg_dst;
  logic [DATA_W-1:0] core_wdata;
  logic              core_stall;
  logic              aux_valid;
  logic [4:0]        aux_dest;
  logic [DATA_W-1:0] aux_data;
  logic              aux_ready;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_we      (core_we),
    .core_rt      (core_rt),
    .core_rd      (core_rd),
    .core_reg_dst (core_reg_dst),
    .core_wdata   (core_wdata),
    .core_stall   (core_stall),
    .aux_valid    (aux_valid),
    .aux_dest     (aux_dest),
    .aux_data     (aux_data),
    .aux_ready    (aux_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a pending aux entry, how many times it has lost, and whether the
  // next cycle is the mandatory aux-only (stall) cycle.
  bit          m_pending;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  int          m_losses;
  bit          m_stall_next;
  bit          e_we, e_stall;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  int          stall_run, stall_run_max;

  task automatic model_step();
    logic [4:0] d;
    bit eff, w;
    logic [4:0] wa;
    logic [31:0] wd;
    w = 0; wa = '0; wd = '0;
    if (rst) begin
      m_pending = 0; m_losses = 0; m_stall_next = 0;
      e_we = 0; e_addr = '0; e_data = '0; e_stall = 0;
      return;
    end
    d = (core_reg_dst == 2'd1) ? core_rd : (core_reg_dst == 2'd2) ? 5'd31 : core_rt;
    eff = core_we && (d != 5'd0);
    if (m_stall_next) begin
      w = 1; wa = m_dest; wd = m_data;
      m_pending = 0; m_stall_next = 0; m_losses = 0;
    end else if (!m_pending) begin
      if (eff) begin w = 1; wa = d; wd = core_wdata; end
      if (aux_valid && aux_dest != 5'd0) begin
        m_pending = 1; m_dest = aux_dest; m_data = aux_data; m_losses = 0;
      end
    end else if (!eff) begin
      w = 1; wa = m_dest; wd = m_data; m_pending = 0;
    end else begin
      w = 1; wa = d; wd = core_wdata;
      if (d == m_dest) m_pending = 0;
      else begin
        m_losses++;
        if (m_losses == MAX_WAIT) m_stall_next = 1;
      end
    end
    e_stall = m_stall_next;
    e_we = w;
    if (w) begin e_addr = wa; e_data = wd; end
  endtask

  task automatic compare_outputs();
    check("rf_we", 32'(rf_we), 32'(e_we));
    check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
    check("rf_wdata", rf_wdata, e_data);
    check("core_stall", 32'(core_stall), 32'(e_stall));
    check("aux_ready", 32'(aux_ready), 32'(!m_pending && !rst));
    if (core_stall) stall_run++; else stall_run = 0;
    if (stall_run > stall_run_max) stall_run_max = stall_run;
  endtask

  task automatic tick(input bit r, input bit we, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [1:0] dst, input logic [31:0] wd,
                      input bit av, input logic [4:0] ad, input logic [31:0] adat);
    @(negedge clk);
    compare_outputs();
    rst = r; core_we = we; core_rt = rt; core_rd = rd; core_reg_dst = dst;
    core_wdata = wd; aux_valid = av; aux_dest = ad; aux_data = adat;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    stall_run = 0; stall_run_max = 0;
    rst = 1; core_we = 0; core_rt = 0; core_rd = 0; core_reg_dst = 0; core_wdata = 0;
    aux_valid = 0; aux_dest = 0; aux_data = 0;
    model_step();
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // core destination selection
    tick(0, 1, 9, 5, 2'b01, 32'hDEADBEEF, 0, 0, 0);
    tick(0, 1, 9, 5, 2'b10, 32'h11111111, 0, 0, 0);
    tick(0, 1, 9, 5, 2'b11, 32'h22222222, 0, 0, 0);
    // $0 suppression on both paths
    tick(0, 1, 0, 5, 2'b00, 32'h33333333, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0, 32'h44444444);
    idle(2);
    // aux with idle core
    tick(0, 0, 0, 0, 0, 0, 1, 7, 32'h1234);
    idle(3);
    // starvation: core hammers reg 3 while aux for reg 7 waits
    tick(0, 0, 0, 0, 0, 0, 1, 7, 32'hA5A5);
    for (int i = 0; i < 7; i++) tick(0, 1, 3, 0, 2'b00, 32'h300 + 32'(i), 0, 0, 0);
    idle(2);
    // same-destination drop
    tick(0, 0, 0, 0, 0, 0, 1, 12, 32'hBBBB);
    tick(0, 1, 0, 12, 2'b01, 32'hAA, 0, 0, 0);
    idle(3);
    // reset while holding an entry
    tick(0, 0, 0, 0, 0, 0, 1, 20, 32'hCCCC);
    tick(0, 1, 4, 0, 2'b00, 32'h404, 0, 0, 0);
    tick(1, 1, 4, 0, 2'b00, 32'h405, 0, 0, 0);
    idle(4);

    // randomized traffic; stall cycles re-present the same core writeback
    for (int i = 0; i < 3000; i++) begin
      bit r, we, av;
      logic [4:0] rt, rd, ad;
      logic [1:0] dst;
      logic [31:0] wd, adat;
      r    = ($urandom_range(99) == 0);
      we   = ($urandom_range(9) < 6);
      rt   = 5'($urandom_range(7));
      rd   = 5'($urandom_range(7));
      dst  = 2'($urandom_range(3));
      wd   = $urandom;
      av   = ($urandom_range(9) < 4);
      ad   = 5'($urandom_range(7));
      adat = $urandom;
      if (core_stall) begin
        we = core_we; rt = core_rt; rd = core_rd; dst = core_reg_dst; wd = core_wdata;
      end
      tick(r, we, rt, rd, dst, wd, av, ad, adat);
    end
    idle(2);
    check("stall_run_max", 32'(stall_run_max), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
